// File: rtl/eth_tx_sequencer_if.sv
`default_nettype none
// == eth_tx_sequencer_if : memory read port and MAC TX FIFO port of the frame sequencer ==
// == Rev 1.0 ==
interface eth_tx_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd_data;
  logic [31:0]       ff_tx_data;
  logic              ff_tx_wren;
  logic              ff_tx_sop;
  logic              ff_tx_eop;
  logic [1:0]        ff_tx_mod;
  logic              ff_tx_err;
  logic              ff_tx_rdy;

  modport master (
    output mem_rd_en, mem_addr, ff_tx_data, ff_tx_wren, ff_tx_sop, ff_tx_eop,
           ff_tx_mod, ff_tx_err,
    input  mem_rd_data, ff_tx_rdy
  );

  modport slave (
    input  mem_rd_en, mem_addr, ff_tx_data, ff_tx_wren, ff_tx_sop, ff_tx_eop,
           ff_tx_mod, ff_tx_err,
    output mem_rd_data, ff_tx_rdy
  );
endinterface
`default_nettype wire

// File: rtl/eth_tx_sequencer.sv
`default_nettype none
// == eth_tx_sequencer : on trigger, streams one fixed-size frame from memory into the MAC TX FIFO ==
// == Rev 1.0 ==
module eth_tx_sequencer #(
  parameter int FRAME_BYTES = 64,
  parameter int ADDR_W      = 8,
  parameter int IPG_CYCLES  = 12
) (
  input  wire logic               clk_hifreq,
  input  wire logic               rst,
  input  wire logic               trigger,
  input  wire logic               cfg_busy,
  eth_tx_sequencer_if.master      bus,
  output logic                    frame_active,
  output logic [15:0]             frames_sent,
  output logic [7:0]              drop_cnt
);

  localparam int WORDS    = (FRAME_BYTES + 3) / 4;
  localparam int LAST_MOD = (4 - (FRAME_BYTES % 4)) % 4;
  localparam int CW       = $clog2(WORDS + 1);

  localparam logic [CW-1:0]     WORDS_C    = CW'(WORDS);
  localparam logic [CW-1:0]     LAST_IDX   = CW'(WORDS - 1);
  localparam logic [ADDR_W-1:0] WORDS_A    = ADDR_W'(WORDS);
  localparam logic [1:0]        LAST_MOD_C = 2'(LAST_MOD);
  localparam logic [7:0]        GAP_LOAD   = 8'((IPG_CYCLES == 0) ? 0 : IPG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [ADDR_W-1:0] frame_base;
  logic [CW-1:0]     rd_cnt;
  logic [CW-1:0]     beat_cnt;
  logic              rd_pend;
  logic [31:0]       buf_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        buf_cnt;
  logic              err_flag;
  logic [7:0]        gap_cnt;

  logic              wren;
  logic              xfer;
  logic              is_last;
  logic              eop_xfer;
  logic [2:0]        occ;
  logic              rd_en;
  logic              accept;
  logic              drop;

  assign wren     = (state == STREAM) && (buf_cnt != 2'd0);
  assign xfer     = wren && bus.ff_tx_rdy;
  assign is_last  = (beat_cnt == LAST_IDX);
  assign eop_xfer = xfer && is_last;
  // Words held or on their way, net of the one leaving this cycle; keeps the 2-entry buffer from overflowing.
  assign occ      = {1'b0, buf_cnt} + {2'b00, rd_pend} - {2'b00, xfer};
  assign rd_en    = (state == STREAM) && (occ < 3'd2) && (rd_cnt != WORDS_C);
  assign accept   = (state == IDLE) && trigger && !cfg_busy;
  assign drop     = trigger && !accept;

  assign bus.mem_rd_en  = rd_en;
  assign bus.mem_addr   = rd_en ? (frame_base + ADDR_W'(rd_cnt)) : '0;
  assign bus.ff_tx_wren = wren;
  assign bus.ff_tx_data = wren ? buf_mem[rd_ptr] : 32'd0;
  assign bus.ff_tx_sop  = wren && (beat_cnt == '0);
  assign bus.ff_tx_eop  = wren && is_last;
  assign bus.ff_tx_mod  = (wren && is_last) ? LAST_MOD_C : 2'd0;
  assign bus.ff_tx_err  = wren && is_last && err_flag;
  assign frame_active   = (state == STREAM);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = STREAM;
      STREAM:  if (eop_xfer) state_nxt = (IPG_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == 8'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_hifreq) begin
    if (rst) begin
      state       <= IDLE;
      frame_base  <= '0;
      rd_cnt      <= '0;
      beat_cnt    <= '0;
      rd_pend     <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      buf_cnt     <= 2'd0;
      err_flag    <= 1'b0;
      gap_cnt     <= 8'd0;
      frames_sent <= 16'd0;
      drop_cnt    <= 8'd0;
    end else begin
      state   <= state_nxt;
      rd_pend <= rd_en;
      buf_cnt <= buf_cnt + {1'b0, rd_pend} - {1'b0, xfer};

      if (rd_en) rd_cnt <= rd_cnt + 1'b1;
      if (rd_pend) begin
        buf_mem[wr_ptr] <= bus.mem_rd_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (xfer) begin
        rd_ptr   <= ~rd_ptr;
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (eop_xfer) begin
        rd_cnt      <= '0;
        beat_cnt    <= '0;
        frame_base  <= frame_base + WORDS_A;
        frames_sent <= frames_sent + 16'd1;
        gap_cnt     <= GAP_LOAD;
      end else if ((state == GAP) && (gap_cnt != 8'd0)) begin
        gap_cnt <= gap_cnt - 8'd1;
      end

      // A stalled eop beat already shows its err bit, so the flag stops sampling there to keep it stable.
      if (state_nxt == IDLE)
        err_flag <= 1'b0;
      else if ((state == STREAM) && cfg_busy && !(wren && is_last))
        err_flag <= 1'b1;

      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_sequencer.sv
`default_nettype none
// == tb_eth_tx_sequencer : directed and random frames checked against a queue-level frame model ==
// == Rev 1.0 ==
module tb_eth_tx_sequencer;

  localparam int FB       = 62;
  localparam int AW       = 8;
  localparam int IPG      = 12;
  localparam int WORDS    = (FB + 3) / 4;
  localparam int LAST_MOD = (4 - (FB % 4)) % 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic        cfg_busy;
  logic        frame_active;
  logic [15:0] frames_sent;
  logic [7:0]  drop_cnt;

  eth_tx_sequencer_if #(.ADDR_W(AW)) bus ();

  eth_tx_sequencer #(
    .FRAME_BYTES (FB),
    .ADDR_W      (AW),
    .IPG_CYCLES  (IPG)
  ) dut (
    .clk_hifreq   (clk),
    .rst          (rst),
    .trigger      (trigger),
    .cfg_busy     (cfg_busy),
    .bus          (bus),
    .frame_active (frame_active),
    .frames_sent  (frames_sent),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [AW-1:0] a);
    return {a, a ^ 8'hA5, ~a, a + 8'd17};
  endfunction

  // Memory returns the addressed word one cycle after the strobe, junk otherwise.
  always @(posedge clk)
    bus.mem_rd_data <= bus.mem_rd_en ? word_at(bus.mem_addr) : $urandom;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  bit            m_active   = 0;
  int            m_gap      = 0;
  logic [15:0]   m_frames   = '0;
  int            m_drop     = 0;
  logic [AW-1:0] m_base     = '0;
  int            m_reads    = 0;
  int            m_beats    = 0;
  int            m_stalls   = 0;
  int            m_t        = 0;
  bit            m_err      = 0;
  bit            m_sop_seen = 0;
  bit            post_rst   = 0;
  bit            prev_stall = 0;
  logic [36:0]   prev_vec   = '0;

  always @(negedge clk) begin
    bit            xfer;
    bit            eop_done;
    bit            accepted;
    int            idx;
    logic [36:0]   vec;
    logic [AW-1:0] ea;
    cyc++;
    xfer     = bus.ff_tx_wren && bus.ff_tx_rdy;
    eop_done = 0;
    idx      = m_beats;
    vec      = {bus.ff_tx_data, bus.ff_tx_sop, bus.ff_tx_eop, bus.ff_tx_mod, bus.ff_tx_err};

    if (post_rst) begin
      check_val("rst_data", bus.ff_tx_data, 32'd0);
      check_val("rst_ctl", {16'd0, bus.mem_rd_en, bus.mem_addr, bus.ff_tx_wren, bus.ff_tx_sop,
                            bus.ff_tx_eop, bus.ff_tx_mod, bus.ff_tx_err, frame_active}, 32'd0);
      check_val("rst_cnt", {8'd0, frames_sent, drop_cnt}, 32'd0);
      post_rst = 0;
    end

    check_val("frame_active", 32'(frame_active), 32'(m_active));
    check_val("frames_sent", 32'(frames_sent), 32'(m_frames));
    check_val("drop_cnt", 32'(drop_cnt), 32'(m_drop));

    if (!m_active) begin
      check_val("idle_strobes", {30'd0, bus.mem_rd_en, bus.ff_tx_wren}, 32'd0);
    end else begin
      if (bus.mem_rd_en) begin
        ea = m_base + AW'(m_reads);
        check_val("rd_addr", 32'(bus.mem_addr), 32'(ea));
        if (m_reads == 0) check_val("rd_latency", 32'(cyc), 32'(m_t + 1));
        m_reads++;
        check_val("rd_count", 32'(m_reads <= WORDS), 32'd1);
      end
      check_val("occupancy", 32'((m_reads - m_beats - int'(xfer)) <= 2), 32'd1);
      if (bus.ff_tx_wren) begin
        ea = m_base + AW'(idx);
        check_val("beat_data", bus.ff_tx_data, word_at(ea));
        check_val("beat_flags", {27'd0, bus.ff_tx_sop, bus.ff_tx_eop, bus.ff_tx_mod, bus.ff_tx_err},
                  {27'd0, idx == 0, idx == WORDS - 1,
                   (idx == WORDS - 1) ? 2'(LAST_MOD) : 2'd0, (idx == WORDS - 1) && m_err});
        if (prev_stall) begin
          check_val("hold_data", bus.ff_tx_data, prev_vec[36:5]);
          check_val("hold_flags", 32'(vec[4:0]), 32'(prev_vec[4:0]));
        end
        if (idx == 0 && !m_sop_seen) begin
          check_val("sop_latency", 32'(cyc), 32'(m_t + 3));
          m_sop_seen = 1;
        end
        if (xfer) begin
          m_beats++;
          if (idx == WORDS - 1) begin
            check_val("eop_latency", 32'(cyc), 32'(m_t + 2 + WORDS + m_stalls));
            eop_done = 1;
          end
        end else begin
          m_stalls++;
        end
      end
      if (cfg_busy && !(bus.ff_tx_wren && idx == WORDS - 1)) m_err = 1;
    end
    prev_stall = bus.ff_tx_wren && !bus.ff_tx_rdy;
    prev_vec   = vec;

    if (rst) begin
      m_active = 0; m_gap = 0; m_frames = '0; m_drop = 0; m_base = '0;
      m_reads = 0; m_beats = 0; m_stalls = 0; m_err = 0; m_sop_seen = 0;
      prev_stall = 0;
      post_rst   = 1;
    end else begin
      accepted = trigger && !cfg_busy && !m_active && (m_gap == 0);
      if (trigger && !accepted && m_drop < 255) m_drop++;
      if (eop_done) begin
        m_active = 0;
        m_frames = m_frames + 16'd1;
        m_base   = m_base + AW'(WORDS);
        m_gap    = IPG;
      end else if (m_gap > 0) begin
        m_gap--;
      end
      if (accepted) begin
        m_active = 1; m_t = cyc; m_reads = 0; m_beats = 0;
        m_stalls = 0; m_sop_seen = 0; m_err = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_active || m_gap != 0) && n < 300) begin
      tick();
      n++;
    end
    check_val("wait_idle_bound", 32'(n < 300), 32'd1);
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (m_beats != target && n < 100) begin
      tick();
      n++;
    end
    check_val("wait_beats_bound", 32'(n < 100), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; trigger = 1'b0; cfg_busy = 1'b0; bus.ff_tx_rdy = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (6) tick();

    // Clean frame with the FIFO always ready.
    pulse_trigger();
    wait_idle();
    check_val("first_frame_count", 32'(frames_sent), 32'd1);

    // One trigger accepted, one dropped mid-stream, one dropped on cfg_busy.
    do_reset();
    pulse_trigger();
    repeat (5) tick();
    pulse_trigger();
    wait_idle();
    cfg_busy = 1'b1;
    pulse_trigger();
    cfg_busy = 1'b0;
    tick();
    check_val("drops_directed", 32'(drop_cnt), 32'd2);
    check_val("frames_directed", 32'(frames_sent), 32'd1);

    // Next frame reads 16..31 and stalls 5 cycles after beat 4.
    pulse_trigger();
    wait_beats(4);
    bus.ff_tx_rdy = 1'b0;
    repeat (5) tick();
    bus.ff_tx_rdy = 1'b1;
    wait_idle();

    // cfg_busy pulse at beat 7 flags only this frame's eop.
    pulse_trigger();
    wait_beats(7);
    cfg_busy = 1'b1;
    tick();
    cfg_busy = 1'b0;
    wait_idle();
    pulse_trigger();
    wait_idle();

    // Reset at beat 8 abandons the frame; the next starts from address 0.
    pulse_trigger();
    wait_beats(8);
    do_reset();
    pulse_trigger();
    wait_idle();
    check_val("after_reset_frames", 32'(frames_sent), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      trigger       = ($urandom % 24) == 0;
      cfg_busy      = ($urandom % 20) == 0;
      bus.ff_tx_rdy = ($urandom % 4) != 0;
      rst           = ($urandom % 700) == 0;
      tick();
    end
    trigger = 1'b0; cfg_busy = 1'b0; rst = 1'b0; bus.ff_tx_rdy = 1'b1;
    wait_idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_tx_sequencer.md
ETH_TX_SEQUENCER -- requirements
Module: eth_tx_sequencer

Interface
REQ-001 Parameter FRAME_BYTES, default 64, payload bytes per frame; legal range 8..1024.
REQ-002 Parameter ADDR_W, default 8, memory address width.
REQ-003 Parameter IPG_CYCLES, default 12, minimum idle cycles after an eop beat before the next sop beat; legal range 0..255.
REQ-004 Derived constants: WORDS = ceil(FRAME_BYTES/4); LAST_MOD = (4 - FRAME_BYTES mod 4) mod 4.
REQ-005 clk_hifreq  in  1  single clock; every register is on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 trigger  in  1  single-cycle frame-send request (the half-second pulse, resynchronised to clk_hifreq).
REQ-008 cfg_busy  in  1  MAC register configuration in progress.
REQ-009 mem_rd_en  out  1  memory read strobe.
REQ-010 mem_addr  out  ADDR_W  memory read address.
REQ-011 mem_rd_data  in  32  read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 ff_tx_data  out  32  MAC TX FIFO data.
REQ-013 ff_tx_wren  out  1  beat valid.
REQ-014 ff_tx_sop, ff_tx_eop  out  1 each  first and last beat markers.
REQ-015 ff_tx_mod  out  2  empty bytes in the eop beat.
REQ-016 ff_tx_err  out  1  frame-error marker.
REQ-017 ff_tx_rdy  in  1  MAC FIFO ready.
REQ-018 frame_active  out  1  high from trigger acceptance until the eop beat is accepted.
REQ-019 frames_sent  out  16  count of completed frames; wraps at 2^16.
REQ-020 drop_cnt  out  8  count of rejected triggers; saturates at 255.

Function
REQ-021 A beat transfers in any cycle where ff_tx_wren && ff_tx_rdy are both high.
REQ-022 While ff_tx_wren=1 and ff_tx_rdy=0, ff_tx_data, sop, eop, mod and err shall hold stable.
REQ-023 FSM states and transitions:
- IDLE -> STREAM on trigger && !cfg_busy.
- STREAM -> GAP on acceptance of the eop beat.
- GAP -> IDLE after IPG_CYCLES cycles; GAP is skipped when IPG_CYCLES=0.
REQ-024 Trigger acceptance: a trigger in IDLE with cfg_busy=0 is accepted. A trigger in STREAM or GAP, or with cfg_busy=1, is dropped and increments drop_cnt.
REQ-025 Read addressing: on acceptance, frame reads use addresses frame_base .. frame_base+WORDS-1, modulo 2^ADDR_W.
REQ-026 frame_base resets to 0 and advances by WORDS, modulo 2^ADDR_W, when the eop beat is accepted.
REQ-027 Buffering: the block contains an internal 2-entry data buffer. A read issues only if (buffered words + reads in flight − words transferring this cycle) < 2 and frame reads remain. No word is lost, duplicated or reordered.
REQ-028 Latency with ff_tx_rdy held at 1 (trigger accepted in cycle T):
- first mem_rd_en in cycle T+1;
- sop beat (ff_tx_wren=1) in cycle T+3;
- one beat per cycle after that;
- eop beat in cycle T+2+WORDS.
REQ-029 Beat markers:
- ff_tx_sop=1 only on word 0;
- ff_tx_eop=1 only on word WORDS-1;
- ff_tx_mod = LAST_MOD on the eop beat and 0 on all other beats.
REQ-030 Error marking: an internal error flag is set if cfg_busy=1 in any cycle of STREAM. ff_tx_err = flag on the eop beat and 0 on all other beats. The flag clears on entry to IDLE.
REQ-031 Counters: frames_sent increments in the cycle after eop acceptance. A simultaneous rejected trigger and eop acceptance updates both counters.
REQ-032 mem_rd_en is 0 outside STREAM. ff_tx_wren is 0 in IDLE and GAP.

Reset
REQ-033 While rst=1, on the next edge:
- all outputs = 0;
- FSM = IDLE;
- frame_base = 0;
- buffer emptied;
- error flag cleared;
- counters = 0.
REQ-034 rst asserted mid-frame abandons the frame without an eop beat. Read data returning the cycle after reset is discarded.

Verification
REQ-035 Defaults, ff_tx_rdy=1, trigger in cycle 10 -> mem_rd_en in cycles 11..26 with mem_addr 0..15; ff_tx_wren in cycles 13..28; sop in 13; eop in 28 with mod=0, err=0; frames_sent=1 in cycle 29.
REQ-036 FRAME_BYTES=62 -> 16 beats; eop beat has ff_tx_mod=2; all other beats have mod=0.
REQ-037 Drop ff_tx_rdy to 0 for 5 cycles after beat 4 -> data held stable; at most 2 words buffered or in flight; all 16 words delivered in order; eop delayed by 5 cycles.
REQ-038 Second trigger during STREAM, and a third trigger with cfg_busy=1 in IDLE -> drop_cnt=2, frames_sent=1. The next accepted frame reads addresses 16..31.
REQ-039 cfg_busy pulsed at beat 7 -> ff_tx_err=1 on the eop beat only; the following clean frame has err=0.
REQ-040 rst at beat 8 -> all outputs 0 next cycle; no eop beat. The next frame starts at address 0 with frames_sent=0.
